// File: rtl/pla_vector_sweeper.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pla_vector_sweeper                                            |
// | Purpose  : Exhaustive 8-input cone sweep: truth-table capture, response  |
// |            signature and optional onset counter (SWEEP_ONSET_COUNT_EN).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pla_vector_sweeper #(
   parameter int          LATENCY  = 0,
   parameter logic [15:0] SIG_POLY = 16'h1021
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic [7:0]  x_out,
   input  logic        y_in,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature,
   output logic [8:0]  onset_count,
   input  logic [7:0]  rd_addr,
   output logic        rd_data
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SWEEP = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam logic [1:0] c_drain_last = 2'((LATENCY > 0) ? (LATENCY - 1) : 0);

   state_t        r_state;
   state_t        w_state_nxt;
   logic [7:0]    r_cnt;
   logic [1:0]    r_drain;
   logic [255:0]  r_table;
   logic [15:0]   r_sig;
   logic          w_start_ok;
   logic          w_smp_vld;
   logic [7:0]    w_smp_idx;
   logic          w_fb;
   logic [15:0]   w_sig_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_start_ok  = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      x_out       = 8'h00;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_start_ok  = 1'b1;
               w_state_nxt = ST_SWEEP;
            end
         end
         ST_SWEEP: begin
            busy  = 1'b1;
            x_out = r_cnt;
            if (r_cnt == 8'hFF) begin
               w_state_nxt = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            busy = 1'b1;
            if (r_drain == c_drain_last) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done = 1'b1;
            if (start) begin
               w_start_ok  = 1'b1;
               w_state_nxt = ST_SWEEP;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Sample point trails the presented vector by LATENCY cycles.
   generate
      if (LATENCY == 0) begin : g_lat0
         assign w_smp_vld = (r_state == ST_SWEEP);
         assign w_smp_idx = r_cnt;
      end else begin : g_latn
         logic [LATENCY-1:0]      r_pv;
         logic [LATENCY-1:0][7:0] r_pi;
         always_ff @(posedge clk) begin
            if (rst) begin
               r_pv <= '0;
               r_pi <= '0;
            end else begin
               r_pv[0] <= (r_state == ST_SWEEP);
               r_pi[0] <= r_cnt;
               for (int i = 1; i < LATENCY; i++) begin
                  r_pv[i] <= r_pv[i-1];
                  r_pi[i] <= r_pi[i-1];
               end
            end
         end
         assign w_smp_vld = r_pv[LATENCY-1];
         assign w_smp_idx = r_pi[LATENCY-1];
      end
   endgenerate

   assign w_fb      = r_sig[15] ^ y_in;
   assign w_sig_nxt = {r_sig[14:0], 1'b0} ^ (w_fb ? SIG_POLY : 16'h0000);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= 8'h00;
         r_drain <= 2'd0;
         r_table <= '0;
         r_sig   <= 16'h0000;
      end else if (w_start_ok) begin
         r_cnt   <= 8'h00;
         r_drain <= 2'd0;
         r_table <= '0;
         r_sig   <= 16'h0000;
      end else begin
         if (r_state == ST_SWEEP) begin
            r_cnt   <= r_cnt + 8'd1;
            r_drain <= 2'd0;
         end else if (r_state == ST_DRAIN) begin
            r_drain <= r_drain + 2'd1;
         end
         if (w_smp_vld) begin
            r_table[w_smp_idx] <= y_in;
            r_sig              <= w_sig_nxt;
         end
      end
   end

`ifdef SWEEP_ONSET_COUNT_EN
   logic [8:0] r_onset;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_onset <= 9'd0;
      end else if (w_start_ok) begin
         r_onset <= 9'd0;
      end else if (w_smp_vld && y_in && (r_onset != 9'd256)) begin
         r_onset <= r_onset + 9'd1;
      end
   end
   assign onset_count = r_onset;
`else
   assign onset_count = 9'd0;
`endif

   assign signature = r_sig;
   assign rd_data   = r_table[rd_addr];

endmodule
`default_nettype wire

// File: tb/tb_pla_vector_sweeper.sv
`default_nettype none
// Bench for pla_vector_sweeper: LATENCY=0 and LATENCY=2 instances swept side by side,
// expected results queued at each start and checked by a done-triggered monitor.
module tb_pla_vector_sweeper;

   typedef struct packed {
      logic [9:0]  busy;
      logic [15:0] sig;
      logic [8:0]  on;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start;
   logic [7:0]  rd_addr;
   logic [1:0]  mode;
   logic [7:0]  x0, x2;
   logic        y0, y2, yd1, yd2;
   logic        busy0, busy2, done0, done2, rd0, rd2;
   logic [15:0] sig0, sig2;
   logic [8:0]  on0, on2;

   int   n_chk  = 0;
   int   n_fail = 0;
   exp_t q0[$];
   exp_t q1[$];
   int   bcnt[2];
   logic pd[2];

   function automatic logic f_resp(input logic [1:0] m, input logic [7:0] v);
      case (m)
         2'd0:    return 1'b0;
         2'd1:    return 1'b1;
         2'd2:    return v[0];
         default: return v[7];
      endcase
   endfunction

   function automatic logic [15:0] ref_sig(input logic [1:0] m);
      logic [15:0] s;
      logic        fb;
      s = 16'h0000;
      for (int v = 0; v < 256; v++) begin
         fb = s[15] ^ f_resp(m, 8'(v));
         s  = {s[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return s;
   endfunction

   function automatic logic [8:0] ref_on(input logic [1:0] m);
      logic [8:0] n;
      n = 9'd0;
`ifdef SWEEP_ONSET_COUNT_EN
      for (int v = 0; v < 256; v++) begin
         if (f_resp(m, 8'(v))) n = n + 9'd1;
      end
`endif
      return n;
   endfunction

   assign y0 = f_resp(mode, x0);
   assign y2 = yd2;
   always @(posedge clk) begin
      yd1 <= f_resp(mode, x2);
      yd2 <= yd1;
   end

   pla_vector_sweeper #(.LATENCY(0), .SIG_POLY(16'h1021)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .x_out(x0), .y_in(y0),
      .busy(busy0), .done(done0), .signature(sig0), .onset_count(on0),
      .rd_addr(rd_addr), .rd_data(rd0)
   );

   pla_vector_sweeper #(.LATENCY(2), .SIG_POLY(16'h1021)) u_dut2 (
      .clk(clk), .rst(rst), .start(start), .x_out(x2), .y_in(y2),
      .busy(busy2), .done(done2), .signature(sig2), .onset_count(on2),
      .rd_addr(rd_addr), .rd_data(rd2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor: per-cycle x_out check, busy length and results on each done rise.
   always @(negedge clk) begin : mon
      logic       b, dn;
      logic [7:0] x;
      exp_t       e;
      logic [15:0] s;
      logic [8:0]  o;
      for (int d = 0; d < 2; d++) begin
         b  = (d == 0) ? busy0 : busy2;
         dn = (d == 0) ? done0 : done2;
         x  = (d == 0) ? x0    : x2;
         s  = (d == 0) ? sig0  : sig2;
         o  = (d == 0) ? on0   : on2;
         if (rst) begin
            bcnt[d] = 0;
         end else begin
            if (dn && !pd[d]) begin
               if ((d == 0) ? (q0.size() == 0) : (q1.size() == 0)) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL unexpected_done dut%0d: got done with empty queue, expected none", d);
               end else begin
                  if (d == 0) e = q0.pop_front();
                  else        e = q1.pop_front();
                  chk($sformatf("busy_len dut%0d", d), 32'(bcnt[d]), 32'(e.busy));
                  chk($sformatf("signature dut%0d", d), 32'(s), 32'(e.sig));
                  chk($sformatf("onset dut%0d", d), 32'(o), 32'(e.on));
               end
            end
            if (b) begin
               chk($sformatf("x_sweep dut%0d", d), 32'(x), (bcnt[d] < 256) ? 32'(bcnt[d]) : 32'd0);
               bcnt[d]++;
            end else begin
               chk($sformatf("x_idle dut%0d", d), 32'(x), 32'd0);
               bcnt[d] = 0;
            end
         end
         pd[d] = dn;
      end
   end

   task automatic push_exp(input logic [1:0] m);
      exp_t e;
      e.sig  = ref_sig(m);
      e.on   = ref_on(m);
      e.busy = 10'd256;
      q0.push_back(e);
      e.busy = 10'd258;
      q1.push_back(e);
   endtask

   task automatic pulse_start;
      start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
   endtask

   task automatic wait_done;
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!(done0 && done2) && n < 600);
      chk("done_timeout", 32'(done0 && done2), 32'd1);
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, " x0"}, 32'(x0), 0);      chk({nm, " x2"}, 32'(x2), 0);
      chk({nm, " busy0"}, 32'(busy0), 0); chk({nm, " busy2"}, 32'(busy2), 0);
      chk({nm, " done0"}, 32'(done0), 0); chk({nm, " done2"}, 32'(done2), 0);
      chk({nm, " sig0"}, 32'(sig0), 0);   chk({nm, " sig2"}, 32'(sig2), 0);
      chk({nm, " on0"}, 32'(on0), 0);     chk({nm, " on2"}, 32'(on2), 0);
      for (int a = 97; a <= 101; a++) begin
         rd_addr = 8'(a);
         #1;
         chk($sformatf("%s rd0[%0d]", nm, a), 32'(rd0), 0);
         chk($sformatf("%s rd2[%0d]", nm, a), 32'(rd2), 0);
      end
   endtask

   task automatic chk_table(input logic [1:0] m);
      for (int a = 0; a < 256; a++) begin
         rd_addr = 8'(a);
         #1;
         chk($sformatf("table0[%0d] mode%0d", a, m), 32'(rd0), 32'(f_resp(m, 8'(a))));
         chk($sformatf("table2[%0d] mode%0d", a, m), 32'(rd2), 32'(f_resp(m, 8'(a))));
      end
   endtask

   // Start a sweep, confirm results were cleared on the start edge, then wait for done.
   task automatic run_sweep(input logic [1:0] m);
      mode = m;
      push_exp(m);
      pulse_start;
      rd_addr = 8'd200;
      #1;
      chk("clr rd0", 32'(rd0), 0);     chk("clr rd2", 32'(rd2), 0);
      chk("clr sig0", 32'(sig0), 0);   chk("clr sig2", 32'(sig2), 0);
      chk("clr on0", 32'(on0), 0);     chk("clr on2", 32'(on2), 0);
      chk("start busy0", 32'(busy0), 1);
      chk("start done2", 32'(done2), 0);
      wait_done;
   endtask

   initial begin
      rst     = 1'b1;
      start   = 1'b0;
      rd_addr = 8'd0;
      mode    = 2'd0;
      repeat (3) @(posedge clk);
      start = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      start = 1'b0;
      chk_zero("reset");

      run_sweep(2'd0);
      chk_table(2'd0);
      run_sweep(2'd2);
      chk_table(2'd2);
      run_sweep(2'd3);
      chk_table(2'd3);

      mode = 2'd2;
      pulse_start;
      repeat (100) @(posedge clk);
      #1;
      chk("abort vector", 32'(x0), 32'd100);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk_zero("after_abort");
      repeat (4) @(posedge clk);
      #1;
      chk_zero("abort_hold");

      run_sweep(2'd2);
      chk_table(2'd2);

      mode = 2'd3;
      push_exp(2'd3);
      pulse_start;
      repeat (50) @(posedge clk);
      #1;
      pulse_start;
      wait_done;
      chk_table(2'd3);

      run_sweep(2'd1);
      chk_table(2'd1);

      @(negedge clk);
      chk("queue0 drained", 32'(q0.size()), 0);
      chk("queue1 drained", 32'(q1.size()), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
